branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_pred_pkg.sv | 22 ++
 rtl/bp_sat_counter.sv | 21 ++
 rtl/branch_predictor.sv | 99 +++++++++
 tb/tb_branch_predictor.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pred_pkg.sv
// Shared types and sizing helpers for the branch predictor.
// Counter encoding doubles as the direction hint (bit 1 = taken).
package branch_pred_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   localparam ctr_t CTR_RST = WNT;

   function automatic int index_w(input int entries);
      return $clog2(entries);
   endfunction

   function automatic int tag_w(input int dw, input int entries);
      return dw - $clog2(entries) - 2;
   endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Two-bit saturating direction counter, next-state only.
// Moves one step toward the resolved outcome, clamping at SNT/ST.
module bp_sat_counter
   import branch_pred_pkg::*;
(
   input  ctr_t cur,
   input  logic taken,
   output ctr_t nxt
);

   always_comb begin
      nxt = cur;
      unique case (cur)
         SNT: nxt = taken ? WNT : SNT;
         WNT: nxt = taken ? WT  : SNT;
         WT:  nxt = taken ? ST  : WNT;
         ST:  nxt = taken ? ST  : WT;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, zero-latency lookup,
// execute-stage update and a saturating mispredict counter.
module branch_predictor
   import branch_pred_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ENTRIES    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] fetchPC,
   output logic                  predTaken,
   output logic [DATA_WIDTH-1:0] predTarget,
   input  logic                  updValid,
   input  logic [DATA_WIDTH-1:0] updPC,
   input  logic                  updTaken,
   input  logic [DATA_WIDTH-1:0] updTarget,
   input  logic                  updPredTaken,
   input  logic [DATA_WIDTH-1:0] updPredTarget,
   output logic                  flush,
   output logic [15:0]           mispredictCount
);

   localparam int INDEX_W = index_w(ENTRIES);
   localparam int TAG_W   = tag_w(DATA_WIDTH, ENTRIES);

   logic                  valid_q  [ENTRIES];
   logic [TAG_W-1:0]      tag_q    [ENTRIES];
   logic [DATA_WIDTH-1:0] target_q [ENTRIES];
   ctr_t                  ctr_q    [ENTRIES];

   logic [INDEX_W-1:0] f_idx;
   logic [INDEX_W-1:0] u_idx;
   logic [TAG_W-1:0]   f_tag;
   logic [TAG_W-1:0]   u_tag;
   logic               f_hit;
   logic               u_hit;
   ctr_t               u_ctr_sat;
   ctr_t               u_ctr_next;
   logic [15:0]        miss_q;
   logic               unused_pc_bits;

   assign f_idx = fetchPC[INDEX_W+1:2];
   assign f_tag = fetchPC[DATA_WIDTH-1:INDEX_W+2];
   assign u_idx = updPC[INDEX_W+1:2];
   assign u_tag = updPC[DATA_WIDTH-1:INDEX_W+2];

   assign unused_pc_bits = ^{fetchPC[1:0], updPC[1:0]};

   assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

   // Lookup reads the registered table, so a same-cycle update is not seen.
   assign predTaken  = f_hit && ctr_q[f_idx][1];
   assign predTarget = predTaken ? target_q[f_idx]
                                 : fetchPC + DATA_WIDTH'(4);

   bp_sat_counter u_sat (
      .cur   (ctr_q[u_idx]),
      .taken (updTaken),
      .nxt   (u_ctr_sat)
   );

   assign u_ctr_next = u_hit    ? u_ctr_sat :
                       updTaken ? WT        : WNT;

   assign flush = updValid &&
                  ((updPredTaken != updTaken) ||
                   (updTaken && (updPredTarget != updTarget)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_RST;
         end
      end else if (updValid) begin
         valid_q[u_idx] <= 1'b1;
         tag_q[u_idx]   <= u_tag;
         ctr_q[u_idx]   <= u_ctr_next;
         if (updTaken || !u_hit) begin
            target_q[u_idx] <= updTarget;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         miss_q <= '0;
      end else if (flush && (miss_q != 16'hFFFF)) begin
         miss_q <= miss_q + 16'd1;
      end
   end

   assign mispredictCount = miss_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor against a table model.
// Directed scenarios plus randomized traffic over a small PC pool.
module tb_branch_predictor;

   localparam int DW = 32;
   localparam int N  = 16;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] fetchPC = '0;
   logic          predTaken;
   logic [DW-1:0] predTarget;
   logic          updValid = 1'b0;
   logic [DW-1:0] updPC = '0;
   logic          updTaken = 1'b0;
   logic [DW-1:0] updTarget = '0;
   logic          updPredTaken = 1'b0;
   logic [DW-1:0] updPredTarget = '0;
   logic          flush;
   logic [15:0]   mispredictCount;

   int checks = 0;
   int failures = 0;

   bit            mv   [N];
   logic [DW-1:0] mtag [N];
   logic [DW-1:0] mtgt [N];
   int            mc   [N];
   int            mcount;

   always #5 clk = ~clk;

   branch_predictor #(
      .DATA_WIDTH (DW),
      .ENTRIES    (N)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .fetchPC         (fetchPC),
      .predTaken       (predTaken),
      .predTarget      (predTarget),
      .updValid        (updValid),
      .updPC           (updPC),
      .updTaken        (updTaken),
      .updTarget       (updTarget),
      .updPredTaken    (updPredTaken),
      .updPredTarget   (updPredTarget),
      .flush           (flush),
      .mispredictCount (mispredictCount)
   );

   function automatic int idx_of(input logic [DW-1:0] pc);
      return int'((pc >> 2) % N);
   endfunction

   function automatic logic [DW-1:0] tag_of(input logic [DW-1:0] pc);
      return pc >> (IW + 2);
   endfunction

   function automatic bit m_hit(input logic [DW-1:0] pc);
      return mv[idx_of(pc)] && (mtag[idx_of(pc)] == tag_of(pc));
   endfunction

   function automatic logic m_taken(input logic [DW-1:0] pc);
      return m_hit(pc) && (mc[idx_of(pc)] >= 2);
   endfunction

   function automatic logic [DW-1:0] m_target(input logic [DW-1:0] pc);
      return m_taken(pc) ? mtgt[idx_of(pc)] : pc + 32'd4;
   endfunction

   function automatic logic m_flush();
      if (!updValid) return 1'b0;
      if (updPredTaken != updTaken) return 1'b1;
      return updTaken && (updPredTarget != updTarget);
   endfunction

   function automatic logic [DW-1:0] rand_pc();
      return 32'h0000_1000
           | (32'($urandom_range(0, 3)) << (IW + 2))
           | (32'($urandom_range(0, N - 1)) << 2);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         mv[i] = 1'b0;
         mtag[i] = '0;
         mtgt[i] = '0;
         mc[i] = 1;
      end
      mcount = 0;
   endtask

   task automatic model_update();
      int i;
      i = idx_of(updPC);
      if (m_flush() && mcount < 65535) mcount++;
      if (m_hit(updPC)) begin
         if (updTaken) begin
            mc[i] = (mc[i] == 3) ? 3 : mc[i] + 1;
            mtgt[i] = updTarget;
         end else begin
            mc[i] = (mc[i] == 0) ? 0 : mc[i] - 1;
         end
      end else begin
         mv[i] = 1'b1;
         mtag[i] = tag_of(updPC);
         mtgt[i] = updTarget;
         mc[i] = updTaken ? 2 : 1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n && updValid) model_update();
      #1;
   endtask

   task automatic set_upd(input logic [DW-1:0] pc, input logic tk,
                          input logic [DW-1:0] tgt);
      updValid = 1'b1;
      updPC = pc;
      updTaken = tk;
      updTarget = tgt;
      updPredTaken = m_taken(pc);
      updPredTarget = m_target(pc);
   endtask

   task automatic test_reset();
      model_clear();
      rst_n = 1'b0;
      fetchPC = 32'h100;
      updValid = 1'b1;
      updPC = 32'h100;
      updTaken = 1'b1;
      updTarget = 32'h200;
      updPredTaken = 1'b0;
      updPredTarget = 32'h104;
      #1;
      checks++;
      if (predTaken !== 1'b0) begin
         failures++;
         $display("FAIL rst_taken got=%0b exp=0", predTaken);
      end
      checks++;
      if (predTarget !== 32'h104) begin
         failures++;
         $display("FAIL rst_target got=%h exp=00000104", predTarget);
      end
      checks++;
      if (flush !== 1'b1) begin
         failures++;
         $display("FAIL rst_flush got=%0b exp=1", flush);
      end
      step();
      checks++;
      if (predTaken !== 1'b0 || mispredictCount !== 16'd0) begin
         failures++;
         $display("FAIL rst_discard taken=%0b cnt=%0d exp 0/0",
                  predTaken, mispredictCount);
      end
      rst_n = 1'b1;
      updValid = 1'b0;
      #1;
      checks++;
      if (predTaken !== 1'b0 || predTarget !== 32'h104) begin
         failures++;
         $display("FAIL post_rst_lookup got=%0b/%h exp=0/00000104",
                  predTaken, predTarget);
      end
      checks++;
      if (mispredictCount !== 16'd0) begin
         failures++;
         $display("FAIL post_rst_cnt got=%0d exp=0", mispredictCount);
      end
   endtask

   task automatic test_first_update();
      fetchPC = 32'h100;
      set_upd(32'h100, 1'b1, 32'h200);
      #1;
      checks++;
      if (flush !== 1'b1) begin
         failures++;
         $display("FAIL first_flush got=%0b exp=1", flush);
      end
      step();
      updValid = 1'b0;
      #1;
      checks++;
      if (predTaken !== 1'b1 || predTarget !== 32'h200) begin
         failures++;
         $display("FAIL first_lookup got=%0b/%h exp=1/00000200",
                  predTaken, predTarget);
      end
      checks++;
      if (mispredictCount !== 16'd1) begin
         failures++;
         $display("FAIL first_cnt got=%0d exp=1", mispredictCount);
      end
   endtask

   task automatic test_saturation();
      fetchPC = 32'h100;
      for (int k = 0; k < 4; k++) begin
         set_upd(32'h100, 1'b0, 32'h0);
         step();
      end
      updValid = 1'b0;
      #1;
      checks++;
      if (predTaken !== 1'b0 || predTarget !== 32'h104) begin
         failures++;
         $display("FAIL sat_low got=%0b/%h exp=0/00000104",
                  predTaken, predTarget);
      end
      set_upd(32'h100, 1'b1, 32'h200);
      step();
      updValid = 1'b0;
      #1;
      checks++;
      if (predTaken !== 1'b0) begin
         failures++;
         $display("FAIL sat_wnt got=%0b exp=0", predTaken);
      end
      set_upd(32'h100, 1'b1, 32'h200);
      step();
      updValid = 1'b0;
      #1;
      checks++;
      if (predTaken !== 1'b1 || predTarget !== 32'h200) begin
         failures++;
         $display("FAIL sat_wt got=%0b/%h exp=1/00000200",
                  predTaken, predTarget);
      end
      checks++;
      if (mispredictCount !== 16'(mcount)) begin
         failures++;
         $display("FAIL sat_cnt got=%0d exp=%0d", mispredictCount, mcount);
      end
   endtask

   task automatic test_alias();
      set_upd(32'h140, 1'b1, 32'h300);
      step();
      updValid = 1'b0;
      fetchPC = 32'h100;
      #1;
      checks++;
      if (predTaken !== 1'b0 || predTarget !== 32'h104) begin
         failures++;
         $display("FAIL alias_old got=%0b/%h exp=0/00000104",
                  predTaken, predTarget);
      end
      fetchPC = 32'h140;
      #1;
      checks++;
      if (predTaken !== 1'b1 || predTarget !== 32'h300) begin
         failures++;
         $display("FAIL alias_new got=%0b/%h exp=1/00000300",
                  predTaken, predTarget);
      end
   endtask

   task automatic test_same_cycle();
      fetchPC = 32'h140;
      set_upd(32'h140, 1'b0, 32'h0);
      #1;
      checks++;
      if (predTaken !== 1'b1 || predTarget !== 32'h300) begin
         failures++;
         $display("FAIL same_old got=%0b/%h exp=1/00000300",
                  predTaken, predTarget);
      end
      step();
      updValid = 1'b0;
      #1;
      checks++;
      if (predTaken !== 1'b0 || predTarget !== 32'h144) begin
         failures++;
         $display("FAIL same_new got=%0b/%h exp=0/00000144",
                  predTaken, predTarget);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 3000; n++) begin
         fetchPC = rand_pc();
         updValid = ($urandom_range(0, 3) != 0);
         updPC = rand_pc();
         updTaken = 1'($urandom_range(0, 1));
         updTarget = $urandom & 32'h0000_fffc;
         if ($urandom_range(0, 3) == 0) begin
            updPredTaken = 1'($urandom_range(0, 1));
            updPredTarget = $urandom & 32'h0000_fffc;
         end else begin
            updPredTaken = m_taken(updPC);
            updPredTarget = m_target(updPC);
         end
         #1;
         checks++;
         if (predTaken !== m_taken(fetchPC)) begin
            failures++;
            $display("FAIL rnd_taken n=%0d pc=%h got=%0b exp=%0b",
                     n, fetchPC, predTaken, m_taken(fetchPC));
         end
         checks++;
         if (predTarget !== m_target(fetchPC)) begin
            failures++;
            $display("FAIL rnd_target n=%0d pc=%h got=%h exp=%h",
                     n, fetchPC, predTarget, m_target(fetchPC));
         end
         checks++;
         if (flush !== m_flush()) begin
            failures++;
            $display("FAIL rnd_flush n=%0d got=%0b exp=%0b",
                     n, flush, m_flush());
         end
         step();
         checks++;
         if (mispredictCount !== 16'(mcount)) begin
            failures++;
            $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d",
                     n, mispredictCount, mcount);
         end
      end
      updValid = 1'b0;
   endtask

   task automatic test_count_saturate();
      updValid = 1'b1;
      updPC = 32'h100;
      updTaken = 1'b0;
      updTarget = 32'h0;
      updPredTaken = 1'b1;
      updPredTarget = 32'h200;
      for (int k = 0; k < 65540; k++) step();
      checks++;
      if (mispredictCount !== 16'hFFFF) begin
         failures++;
         $display("FAIL cnt_sat got=%h exp=ffff", mispredictCount);
      end
      step();
      checks++;
      if (mispredictCount !== 16'(mcount)) begin
         failures++;
         $display("FAIL cnt_hold got=%h exp=%h", mispredictCount, 16'(mcount));
      end
      updValid = 1'b0;
   endtask

   task automatic test_reset_mid_update();
      fetchPC = 32'h140;
      set_upd(32'h100, 1'b1, 32'h500);
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      checks++;
      if (mispredictCount !== 16'd0) begin
         failures++;
         $display("FAIL mid_rst_cnt got=%0d exp=0", mispredictCount);
      end
      step();
      rst_n = 1'b1;
      updValid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         fetchPC = (k == 0) ? 32'h100 : rand_pc();
         #1;
         checks++;
         if (predTaken !== 1'b0 || predTarget !== fetchPC + 32'd4) begin
            failures++;
            $display("FAIL mid_rst_inv pc=%h got=%0b/%h exp=0/%h",
                     fetchPC, predTaken, predTarget, fetchPC + 32'd4);
         end
      end
      fetchPC = 32'h100;
      set_upd(32'h100, 1'b1, 32'h500);
      step();
      updValid = 1'b0;
      #1;
      checks++;
      if (predTaken !== 1'b1 || predTarget !== 32'h500) begin
         failures++;
         $display("FAIL mid_rst_first got=%0b/%h exp=1/00000500",
                  predTaken, predTarget);
      end
      checks++;
      if (mispredictCount !== 16'(mcount)) begin
         failures++;
         $display("FAIL mid_rst_cnt2 got=%0d exp=%0d",
                  mispredictCount, mcount);
      end
   endtask

   initial begin
      test_reset();
      test_first_update();
      test_saturation();
      test_alias();
      test_same_cycle();
      test_random();
      test_count_saturate();
      test_reset_mid_update();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
